// File: rtl/multi_edge_detect_amisha.sv
// Multi-channel synchronised edge detector with sticky pending flags,
// shared irq and saturating event counter. Define DEBOUNCE_EN for debounce.
module multi_edge_detect_amisha #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic [N-1:0]     level_amisha,
  input  logic [2*N-1:0]   mode_amisha,
  input  logic [N-1:0]     clr_amisha,
  input  logic             cnt_clr_amisha,
  output logic [N-1:0]     tick_amisha,
  output logic [N-1:0]     pend_amisha,
  output logic             irq_amisha,
  output logic [CNT_W-1:0] cnt_amisha
);

  localparam int PW = $clog2(N + 1);
  localparam int SW = CNT_W + PW;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } lvl_e;

  if (N < 1 || N > 32) begin : g_bad_n
    $error("N out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 1");
  end

`ifdef DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
`endif

  logic [SYNC_STAGES-1:0][N-1:0] sync;
  logic [N-1:0]                  s;
  logic [N-1:0]                  f;
  logic [N-1:0]                  qual;
  logic [PW-1:0]                 inc;
  logic [CNT_W-1:0]              base;
  logic [SW-1:0]                 sum;
  logic [CNT_W-1:0]              cnt_nx;

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], level_amisha};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    lvl_e state;
    lvl_e state_nx;
    logic take;
    logic rise;
    logic fall;

`ifdef DEBOUNCE_EN
    logic [DEB_W-1:0] deb;

    // Accept the new level only after it has differed for DEB_CYCLES cycles
    assign take = (deb == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
        deb <= '0;
      end else if (s[i] == f[i] || take) begin
        deb <= '0;
      end else begin
        deb <= deb + 1'b1;
      end
    end
`else
    assign take = 1'b1;
`endif

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
        state <= LOW;
      end else begin
        state <= state_nx;
      end
    end

    always_comb begin
      state_nx = state;
      rise     = 1'b0;
      fall     = 1'b0;
      unique case (state)
        LOW: begin
          if (take && s[i]) begin
            state_nx = HIGH;
            rise     = 1'b1;
          end
        end
        HIGH: begin
          if (take && !s[i]) begin
            state_nx = LOW;
            fall     = 1'b1;
          end
        end
        default: state_nx = LOW;
      endcase
    end

    assign f[i]    = (state == HIGH);
    assign qual[i] = (rise & mode_amisha[2*i])
                   | (fall & mode_amisha[2*i+1]);
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < N; i++) begin
      inc = inc + PW'(qual[i]);
    end
  end

  // Clear is applied before this cycle's edges are added
  assign base   = cnt_clr_amisha ? '0 : cnt_amisha;
  assign sum    = SW'(base) + SW'(inc);
  assign cnt_nx = (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      tick_amisha <= '0;
      pend_amisha <= '0;
      cnt_amisha  <= '0;
    end else begin
      tick_amisha <= qual;
      pend_amisha <= (pend_amisha & ~clr_amisha) | qual;
      cnt_amisha  <= cnt_nx;
    end
  end

  assign irq_amisha = |pend_amisha;

endmodule

// File: doc/multi_edge_detect_amisha.md
Name: multi_edge_detect_amisha

Overview:
Parametrised multi-channel edge detector, the successor to the single-channel Mealy rising-edge ticker. Each channel synchronises an asynchronous level and detects rising, falling or both edges under a per-channel mode. Each detected edge produces a registered one-cycle tick and sets a sticky pending flag. A shared interrupt and a saturating event counter feed the status/interrupt logic of the surrounding design.

Parameters:
N, 8, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
CNT_W, 16, width of the saturating event counter
DEB_CYCLES, 4, stable cycles required before a level change is accepted (used only with DEBOUNCE_EN; >=1)

Ports:
clk_amisha  in  1  single clock, rising edge
reset_amisha  in  1  asynchronous, active-high reset
level_amisha  in  N  asynchronous input levels, one bit per channel
mode_amisha  in  2N  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr_amisha  in  N  write-1-to-clear pulse for pend_amisha
cnt_clr_amisha  in  1  synchronous clear of the event counter
tick_amisha  out  N  registered one-cycle pulse per qualified edge
pend_amisha  out  N  sticky pending flags
irq_amisha  out  1  OR of pend_amisha (combinational from registers)
cnt_amisha  out  CNT_W  saturating count of qualified edges, all channels

Behaviour:
- Reset (asynchronous, active-high): sync chains, filtered level f, debounce counters, tick, pend and cnt all go to 0. irq therefore goes to 0.
- Per channel: level passes through SYNC_STAGES flops to give synchronised level s.
- Filtered level f is a 2-state FSM per channel, LOW (f=0) and HIGH (f=1).
  - Transition LOW->HIGH is a rise; HIGH->LOW is a fall.
  - Without debounce: f <= s every cycle, so a transition occurs whenever s != f.
- Qualified edge: rise when mode[0]=1, or fall when mode[1]=1. Mode is sampled in the same cycle the transition occurs.
- Mode 00 suppresses tick and pend, but f still tracks s.
- Mode changes take effect on the next transition. No retroactive ticks are generated.
- tick[i] is registered: high for exactly one cycle, in the cycle after the clock edge where f changes.
- Latency with SYNC_STAGES=2 and no debounce: level changes before edge E0; tick is high from E2 to E3.
- Each SYNC_STAGES increment adds one cycle of latency.
- Back-to-back edges: a pulse on level lasting >=1 cycle after synchronisation, in mode 11, gives two ticks separated by the pulse width.
- pend[i] is set on tick[i] (same edge as tick is registered) and cleared by clr[i].
  - Simultaneous set and clear: set wins, pend stays 1.
  - Clear while pend=0 has no effect.
- irq = |pend.
- cnt: each cycle, cnt <= sat(cnt + popcount(qualified edges this cycle)). It saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr together with edges: cnt <= popcount(edges). Clear is applied first, then the add.
- Level held high through reset release: s and f start at 0, so one rise is detected after release (tick with SYNC_STAGES=2 at the third edge after release). This is intended and documented.
- Reset asserted mid-operation: everything clears immediately. In-flight edges are lost and no partial tick is emitted.

Optional Feature:
Macro DEBOUNCE_EN.
- Defined: per-channel counter of width clog2(DEB_CYCLES)+1.
  - While s != f, the counter increments each cycle.
  - When s != f and count == DEB_CYCLES-1, f <= s, the counter is cleared and the edge is evaluated.
  - Any cycle with s == f clears the counter, so glitches shorter than DEB_CYCLES cycles are discarded.
  - Latency increases by DEB_CYCLES-1 cycles; DEB_CYCLES=1 behaves identically to no debounce.
- Not defined: no counters are instantiated; f <= s directly; DEB_CYCLES is ignored.

Test Plan:
- N=8, SYNC_STAGES=2, mode ch0=01: raise level[0] before E0 -> tick[0]=1 for exactly E2..E3, pend[0]=1, irq=1, cnt=1; lowering level gives no further tick.
- Mode ch3=11: level[3] high for 5 cycles then low -> two ticks 5 cycles apart, cnt=2. Repeat with mode=00 -> no tick, pend[3]=0, cnt unchanged.
- Pend clear collision: assert clr[0] in the same cycle tick[0] is registered -> pend[0] stays 1. Clear again alone -> pend[0]=0, irq=0.
- Counter with CNT_W=4: 8 channels in mode 01 rise together on the same cycle, twice -> cnt=15 (saturated). Assert cnt_clr together with a 3-channel edge -> cnt=3.
- Reset: hold level[1]=1 through reset, deassert -> one tick[1] on the third edge after release. Assert reset mid-pulse -> all outputs 0 immediately.
- DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle high glitch on level[2] -> no tick. A 4-cycle stable high -> tick[2], occurring 3 cycles later than the same stimulus without debounce.
